alu_arbiter: RTL

Shares the single serial-operand alu between NREQ requesters. It arbitrates requests round-robin and sequences the alu operand protocol: valid with operand A, then operand B on the next cycle. It waits for alu ready, assembles the 8- or 16-bit result and returns it to the granted requester. A watchdog aborts hung transactions and resets the alu.

---
 rtl/alu_ctrl_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 58 +++++
 rtl/alu_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared constants, state encoding and helpers for the alu arbiter
//
// Purpose: op codes understood by the serial alu, the transaction state
// enum used by alu_arbiter, and a helper telling how many result bytes an
// op produces.
// Ports: none (package).
package alu_ctrl_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT1,
    WAIT2,
    ABORT,
    DONE
  } state_t;

  // mul returns product low/high, div returns quotient/remainder
  function automatic logic is_two_byte(input logic [1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin request picker with its own rotating pointer
//
// Purpose: combinationally picks the first asserted request starting at the
// pointer; when advance is high the pointer moves to winner+1 mod NREQ.
// Ports:
//   clk, rst  clock and synchronous active-high reset (pointer -> 0)
//   req       per-requester request levels
//   advance   commit the current pick (a grant is being issued)
//   grant     one-hot pick, all zero when no request
//   winner    index of the pick
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic                     advance,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  winner
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] ptr;

  always_comb begin : search
    logic           found;
    logic [IDX_W:0] pos;
    logic [IDX_W-1:0] sel;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    sel    = '0;
    for (int i = 0; i < NREQ; i++) begin
      // wrap ptr+i into 0..NREQ-1 using one spare bit of headroom
      pos = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (pos >= (IDX_W + 1)'(NREQ)) begin
        pos = pos - (IDX_W + 1)'(NREQ);
      end
      sel = pos[IDX_W-1:0];
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        winner     = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (winner == IDX_W'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one serial-operand alu between NREQ requesters
//
// Purpose: round-robin grants the alu, streams operand A then B, collects one
// or two result bytes, and aborts (pulsing alu_rst) when the alu stalls.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req/op/a/b      per-requester request level, op code and operands (packed)
//   gnt, done       one-hot owner and one-cycle completion pulse (registered)
//   res, err        16-bit result and timeout flag, valid with done
//   alu_in/op/valid operand bus, op code and start strobe to the alu
//   alu_rst         alu reset: rst or the one-cycle abort
//   alu_o/alu_ready result byte and its strobe from the alu
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      op,
  input  logic [DATA_W*NREQ-1:0] a,
  input  logic [DATA_W*NREQ-1:0] b,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [15:0]            res,
  output logic                   err,
  output logic [DATA_W-1:0]      alu_in,
  output logic [1:0]             alu_op,
  output logic                   alu_valid,
  output logic                   alu_rst,
  input  logic [DATA_W-1:0]      alu_o,
  input  logic                   alu_ready
);

  localparam int IDX_W = $clog2(NREQ);
  // one extra bit so the counter can never wrap before the compare fires
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_t state, state_next;

  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  winner;
  logic              advance;

  logic [1:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       res_q;
  logic [NREQ-1:0]   gnt_q, done_q;
  logic              err_q;

  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic              two_byte;
  logic              timeout_hit;

  assign advance     = (state == IDLE) && (|req);
  assign two_byte    = is_two_byte(op_q);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (advance),
    .grant   (grant),
    .winner  (winner)
  );

  // operand mux for the winning requester
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_op = op[2*i +: 2];
        sel_a  = a[DATA_W*i +: DATA_W];
        sel_b  = b[DATA_W*i +: DATA_W];
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic; alu_ready takes priority over the timeout
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (|req) state_next = SEND_A;
      SEND_A: state_next = SEND_B;
      SEND_B: state_next = WAIT1;
      WAIT1: begin
        if (alu_ready)        state_next = two_byte ? WAIT2 : DONE;
        else if (timeout_hit) state_next = ABORT;
      end
      WAIT2: begin
        if (alu_ready)        state_next = DONE;
        else if (timeout_hit) state_next = ABORT;
      end
      ABORT:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      res_q  <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (advance) begin
            op_q  <= sel_op;
            a_q   <= sel_a;
            b_q   <= sel_b;
            res_q <= '0;
          end
        end
        SEND_B: cnt <= '0;
        WAIT1: begin
          if (alu_ready) begin
            res_q[7:0] <= alu_o;
            if (!two_byte) res_q[15:8] <= '0;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT2: begin
          if (alu_ready) res_q[15:8] <= alu_o;
          else           cnt <= cnt + 1'b1;
        end
        ABORT:   res_q <= '0;
        default: ;
      endcase

      if (state == IDLE)      gnt_q <= grant;
      else if (state == DONE) gnt_q <= '0;

      done_q <= (state_next == DONE) ? gnt_q : '0;
      err_q  <= (state == ABORT);
    end
  end

  // alu-side outputs decoded from the current state
  always_comb begin
    alu_valid = (state == SEND_A);
    alu_op    = (state == IDLE) ? 2'b00 : op_q;
    alu_rst   = rst || (state == ABORT);
    case (state)
      IDLE:    alu_in = '0;
      SEND_A:  alu_in = a_q;
      default: alu_in = b_q;
    endcase
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign res  = res_q;
  assign err  = err_q;

endmodule
